// File: rtl/uart_rx_packet_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_packet_pkg                                            |
// | Desc     : Shared constants, state encodings and checksum helper for     |
// |            the UART position-packet receiver (UART_RX_CHECKSUM_EN).      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uart_rx_packet_pkg;

    localparam logic [7:0] c_header_default = 8'hA5;

`ifdef UART_RX_CHECKSUM_EN
    localparam int c_pkt_len = 6;
`else
    localparam int c_pkt_len = 5;
`endif

    typedef enum logic [2:0] {
        BYTE_IDLE    = 3'd0,
        BYTE_START   = 3'd1,
        BYTE_DATA    = 3'd2,
        BYTE_STOP    = 3'd3,
        BYTE_CLEANUP = 3'd4
    } byte_state_t;

    typedef enum logic [2:0] {
        P_HDR = 3'd0,
        P_XH  = 3'd1,
        P_XL  = 3'd2,
        P_YH  = 3'd3,
        P_YL  = 3'd4,
        P_CK  = 3'd5
    } pkt_state_t;

    function automatic logic [7:0] payload_checksum(input logic [7:0] a, input logic [7:0] b,
                                                    input logic [7:0] c, input logic [7:0] d);
        return a ^ b ^ c ^ d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_packet_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_byte                                                  |
// | Desc     : 2-FF line synchroniser and 8N1 byte deserialiser.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_byte
    import uart_rx_packet_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_frame_err
);

    localparam int                  c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic               r_sync1;
    logic               r_sync2;
    byte_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= BYTE_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync1     <= i_Rx_Serial;
            r_sync2     <= r_sync1;
            o_Rx_DV     <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                BYTE_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!r_sync2) r_state <= BYTE_START;
                end
                BYTE_START: begin
                    // Re-check the line at mid start bit so short glitches are dropped
                    if (r_cnt == c_half) begin
                        r_cnt   <= '0;
                        r_state <= r_sync2 ? BYTE_IDLE : BYTE_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                BYTE_DATA: begin
                    if (r_cnt == c_last) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_sync2;
                        if (r_bit_idx == 3'd7) r_state <= BYTE_STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                BYTE_STOP: begin
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= BYTE_CLEANUP;
                        if (r_sync2) begin
                            o_Rx_DV   <= 1'b1;
                            o_Rx_Byte <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                BYTE_CLEANUP: r_state <= BYTE_IDLE;
                default:      r_state <= BYTE_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_packet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_packet                                                |
// | Desc     : UART position-packet receiver (A5 XH XL YH YL [CK]);          |
// |            UART_RX_CHECKSUM_EN adds the trailing XOR checksum byte.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_packet
    import uart_rx_packet_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] HEADER       = c_header_default,
    parameter int         TIMEOUT_CLKS = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
    output logic [7:0]  o_Rx_Byte,
    output logic        o_frame_err,
    output logic        o_pkt_valid,
    output logic        o_pkt_err,
    output logic [15:0] o_data_x,
    output logic [15:0] o_data_y
);

    localparam int                 c_to_w     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_to_w-1:0] c_to_limit = c_to_w'(TIMEOUT_CLKS);

    logic       w_dv;
    logic [7:0] w_byte;
    logic       w_fe;

    pkt_state_t         r_state;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [7:0]         r_xh;
    logic [7:0]         r_xl;
    logic [7:0]         r_yh;
`ifdef UART_RX_CHECKSUM_EN
    logic [7:0]         r_yl;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk         (clk),
        .rst         (rst),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_DV     (w_dv),
        .o_Rx_Byte   (w_byte),
        .o_frame_err (w_fe)
    );

    assign o_Rx_DV     = w_dv;
    assign o_Rx_Byte   = w_byte;
    assign o_frame_err = w_fe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= P_HDR;
            r_to_cnt    <= '0;
            r_xh        <= '0;
            r_xl        <= '0;
            r_yh        <= '0;
`ifdef UART_RX_CHECKSUM_EN
            r_yl        <= '0;
`endif
            o_pkt_valid <= 1'b0;
            o_pkt_err   <= 1'b0;
            o_data_x    <= '0;
            o_data_y    <= '0;
        end else begin
            o_pkt_valid <= 1'b0;
            o_pkt_err   <= 1'b0;

            // Idle timer only matters once a header has been accepted
            if (r_state == P_HDR || w_dv) r_to_cnt <= '0;
            else                          r_to_cnt <= r_to_cnt + c_to_w'(1);

            if (r_state != P_HDR && w_fe) begin
                r_state   <= P_HDR;
                o_pkt_err <= 1'b1;
            end else if (w_dv) begin
                case (r_state)
                    P_HDR: if (w_byte == HEADER) r_state <= P_XH;
                    P_XH: begin
                        r_xh    <= w_byte;
                        r_state <= P_XL;
                    end
                    P_XL: begin
                        r_xl    <= w_byte;
                        r_state <= P_YH;
                    end
                    P_YH: begin
                        r_yh    <= w_byte;
                        r_state <= P_YL;
                    end
`ifdef UART_RX_CHECKSUM_EN
                    P_YL: begin
                        r_yl    <= w_byte;
                        r_state <= P_CK;
                    end
                    P_CK: begin
                        r_state <= P_HDR;
                        if (w_byte == payload_checksum(r_xh, r_xl, r_yh, r_yl)) begin
                            o_data_x    <= {r_xh, r_xl};
                            o_data_y    <= {r_yh, r_yl};
                            o_pkt_valid <= 1'b1;
                        end else begin
                            o_pkt_err <= 1'b1;
                        end
                    end
`else
                    P_YL: begin
                        r_state     <= P_HDR;
                        o_data_x    <= {r_xh, r_xl};
                        o_data_y    <= {r_yh, w_byte};
                        o_pkt_valid <= 1'b1;
                    end
`endif
                    default: r_state <= P_HDR;
                endcase
            end else if (r_state != P_HDR && r_to_cnt == c_to_limit) begin
                r_state   <= P_HDR;
                r_to_cnt  <= '0;
                o_pkt_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_packet                                             |
// | Desc     : Self-checking bench for uart_rx_packet with a byte/packet     |
// |            level reference model (honours UART_RX_CHECKSUM_EN).          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx_packet;

    localparam int CPB = 87;
    localparam int TO  = 2000;
`ifdef UART_RX_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        o_Rx_DV;
    logic [7:0]  o_Rx_Byte;
    logic        o_frame_err;
    logic        o_pkt_valid;
    logic        o_pkt_err;
    logic [15:0] o_data_x;
    logic [15:0] o_data_y;

    always #5 clk = ~clk;

    uart_rx_packet #(
        .CLKS_PER_BIT (CPB),
        .HEADER       (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_frame_err (o_frame_err),
        .o_pkt_valid (o_pkt_valid),
        .o_pkt_err   (o_pkt_err),
        .o_data_x    (o_data_x),
        .o_data_y    (o_data_y)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expectations produced per sent byte, consumed by the checker
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_pkts[$];
    int          n_fe_exp  = 0;
    int          n_err_exp = 0;
    int          pos       = 0;
    logic [7:0]  pl[4];

    task automatic mdl_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            n_fe_exp++;
            if (pos != 0) n_err_exp++;
            pos = 0;
        end else begin
            exp_bytes.push_back(b);
            if (pos == 0) begin
                if (b == 8'hA5) pos = 1;
            end else if (pos <= 4) begin
                pl[pos-1] = b;
                pos++;
                if (pos == 5 && !CK_EN) begin
                    exp_pkts.push_back({pl[0], pl[1], pl[2], pl[3]});
                    pos = 0;
                end
            end else begin
                if (b == (pl[0] ^ pl[1] ^ pl[2] ^ pl[3]))
                    exp_pkts.push_back({pl[0], pl[1], pl[2], pl[3]});
                else
                    n_err_exp++;
                pos = 0;
            end
        end
    endtask

    // Checker: owns the read side of the expectation streams and the held-value model
    bit         chk_en      = 1'b0;
    int         rd_byte     = 0;
    int         rd_pkt      = 0;
    int         n_fe_seen   = 0;
    int         n_err_seen  = 0;
    int         last_dv_cyc = 0;
    logic [7:0] mdl_byte    = 8'h00;
    logic [15:0] mdl_x      = 16'h0;
    logic [15:0] mdl_y      = 16'h0;

    initial forever begin
        @(negedge clk);
        if (!chk_en) begin
            rd_byte    = exp_bytes.size();
            rd_pkt     = exp_pkts.size();
            n_fe_seen  = n_fe_exp;
            n_err_seen = n_err_exp;
            mdl_byte   = 8'h00;
            mdl_x      = 16'h0;
            mdl_y      = 16'h0;
        end else begin
            if (o_Rx_DV) begin
                check("dv_expected", 32'(rd_byte < exp_bytes.size()), 32'd1);
                if (rd_byte < exp_bytes.size()) begin
                    mdl_byte = exp_bytes[rd_byte];
                    rd_byte++;
                end
                last_dv_cyc = cyc;
            end
            check("rx_byte", 32'(o_Rx_Byte), 32'(mdl_byte));
            if (o_frame_err) begin
                check("frame_err_expected", 32'(n_fe_seen < n_fe_exp), 32'd1);
                check("frame_err_no_dv", 32'(o_Rx_DV), 32'd0);
                n_fe_seen++;
            end
            if (o_pkt_valid) begin
                check("pkt_valid_expected", 32'(rd_pkt < exp_pkts.size()), 32'd1);
                if (rd_pkt < exp_pkts.size()) begin
                    {mdl_x, mdl_y} = exp_pkts[rd_pkt];
                    rd_pkt++;
                end
            end
            if (o_pkt_err) begin
                check("pkt_err_expected", 32'(n_err_seen < n_err_exp), 32'd1);
                n_err_seen++;
            end
            check("data_x", 32'(o_data_x), 32'(mdl_x));
            check("data_y", 32'(o_data_y), 32'(mdl_y));
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t_start = 0;

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        mdl_rx(b, stop_ok);
        t_start = cyc;
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_ok;
        // A bad stop bit is held past the mid-bit sample, then released
        wait_clks(stop_ok ? CPB : 60);
        rx = 1'b1;
        if (!stop_ok) wait_clks(CPB - 60 + 20);
    endtask

    task automatic gap();
        rx = 1'b1;
        wait_clks($urandom_range(0, 100));
    endtask

    task automatic send_pkt(input logic [7:0] xh, input logic [7:0] xl, input logic [7:0] yh,
                            input logic [7:0] yl, input bit bad_ck);
        logic [7:0] ck;
        ck = xh ^ xl ^ yh ^ yl;
        if (bad_ck) ck = ck ^ (8'h01 << $urandom_range(0, 7));
        send_byte(8'hA5); gap();
        send_byte(xh);    gap();
        send_byte(xl);    gap();
        send_byte(yh);    gap();
        send_byte(yl);
        if (CK_EN) begin
            gap();
            send_byte(ck);
        end
    endtask

    task automatic idle_timeout();
        if (pos != 0) n_err_exp++;
        pos = 0;
        rx = 1'b1;
        wait_clks(TO + 1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (k < 3000 && !(rd_byte == exp_bytes.size() && rd_pkt == exp_pkts.size() &&
                             n_fe_seen == n_fe_exp && n_err_seen == n_err_exp)) begin
            wait_clks(1);
            k++;
        end
        wait_clks(5);
        check({tag, "_bytes"},  32'(rd_byte),    32'(exp_bytes.size()));
        check({tag, "_pkts"},   32'(rd_pkt),     32'(exp_pkts.size()));
        check({tag, "_ferr"},   32'(n_fe_seen),  32'(n_fe_exp));
        check({tag, "_pkterr"}, 32'(n_err_seen), 32'(n_err_exp));
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        rx     = 1'b1;
        wait_clks(3);
        check("rst_dv",     32'(o_Rx_DV),     32'd0);
        check("rst_byte",   32'(o_Rx_Byte),   32'd0);
        check("rst_ferr",   32'(o_frame_err), 32'd0);
        check("rst_pvalid", 32'(o_pkt_valid), 32'd0);
        check("rst_perr",   32'(o_pkt_err),   32'd0);
        check("rst_x",      32'(o_data_x),    32'd0);
        check("rst_y",      32'(o_data_y),    32'd0);
        pos = 0;
        rst = 1'b0;
        wait_clks(3);
        chk_en = 1'b1;
    endtask

    initial begin
        int lat;
        wait_clks(1);
        do_reset();

        // single byte and its latency from the start edge
        send_byte(8'h37);
        wait_clks(20);
        lat = last_dv_cyc - t_start;
        check("dv_latency_ok", 32'(lat >= 820 && lat <= 845), 32'd1);
        check("byte_37", 32'(o_Rx_Byte), 32'h37);
        drain("t1");

        // basic packet
        send_pkt(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        drain("t2");
        check("t2_x", 32'(o_data_x), 32'h1234);
        check("t2_y", 32'(o_data_y), 32'h5678);

        // frame error mid-packet
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h9C, 1'b0);
        drain("t3");
        check("t3_x_hold", 32'(o_data_x), 32'h1234);
        check("t3_y_hold", 32'(o_data_y), 32'h5678);

        // short low glitch, then a good byte
        rx = 1'b0;
        wait_clks(40);
        rx = 1'b1;
        wait_clks(200);
        send_byte(8'h55);
        drain("t4");
        check("byte_55", 32'(o_Rx_Byte), 32'h55);

        // inter-byte timeout, recovery, then reset mid-byte
        send_byte(8'hA5);
        send_byte(8'h12);
        idle_timeout();
        drain("t5a");
        send_pkt(8'hAB, 8'hCD, 8'hEF, 8'h01, 1'b0);
        drain("t5b");
        check("t5_x", 32'(o_data_x), 32'hABCD);
        check("t5_y", 32'(o_data_y), 32'hEF01);
        rx = 1'b0;
        wait_clks(300);
        do_reset();
        send_byte(8'h3C);
        drain("t5c");
        check("byte_3c", 32'(o_Rx_Byte), 32'h3C);

        if (CK_EN) begin
            send_pkt(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
            drain("t6a");
            check("t6_x", 32'(o_data_x), 32'h1234);
            send_byte(8'hA5); send_byte(8'hBE); send_byte(8'hEF);
            send_byte(8'h00); send_byte(8'h11);
            send_byte(8'hBE ^ 8'hEF ^ 8'h00 ^ 8'h11 ^ 8'h01);
            drain("t6b");
            check("t6_x_hold", 32'(o_data_x), 32'h1234);
            check("t6_y_hold", 32'(o_data_y), 32'h5678);
        end

        // randomized mix of packets, junk, frame errors and aborted packets
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 4))
                0: send_pkt(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
                1: send_byte(8'($urandom));
                2: send_byte(8'($urandom), 1'b0);
                3: send_pkt(8'hA5, 8'($urandom), 8'hA5, 8'($urandom), 1'($urandom_range(0, 1)));
                default: begin
                    send_byte(8'hA5);
                    gap();
                    send_byte(8'($urandom));
                    idle_timeout();
                end
            endcase
            gap();
        end
        idle_timeout();
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
